// File: rtl/pipe_skid.sv
// pipe_skid: registered valid/ready pipeline stage with a one-entry skid buffer.
// Feeds the W_DATA-wide input of pipe_pal. o_valid, o_ready and o_data all
// come straight from flops, so no combinational path crosses the stage in
// either direction. It still sustains one transfer per cycle.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst        synchronous active-high reset
//   i_valid      upstream valid
//   o_ready      stage can accept (registered)
//   i_data       upstream payload [W_DATA]
//   o_valid      downstream valid (registered)
//   i_ready      downstream can accept
//   o_data       downstream payload [W_DATA] (registered)
//   o_xfer_count output handshake count [W_CNT]; only with PIPE_SKID_STATS_EN
//
// Optional feature macro: PIPE_SKID_STATS_EN (adds o_xfer_count and its counter).
module pipe_skid #(
  parameter int W_DATA = 32,
  parameter int W_CNT  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [W_DATA-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [W_DATA-1:0] o_data
`ifdef PIPE_SKID_STATS_EN
  ,
  output logic [W_CNT-1:0]  o_xfer_count
`endif
);

  if (W_DATA < 1 || W_CNT < 1) begin : g_bad_param
    $error("pipe_skid: W_DATA and W_CNT must be at least 1");
  end

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [W_DATA-1:0] skid_q;
  logic              acc_in, acc_out;
  logic              load_out_in;   // OUT <= i_data
  logic              load_out_skid; // OUT <= SKID
  logic              load_skid;     // SKID <= i_data

  // Handshakes use the registered outputs, so i_ready never reaches o_ready.
  assign acc_in  = i_valid && o_ready;
  assign acc_out = o_valid && i_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state_q)
      EMPTY: begin
        if (acc_in) begin
          load_out_in = 1'b1;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        case ({acc_in, acc_out})
          2'b11: load_out_in = 1'b1;
          2'b10: begin
            load_skid = 1'b1;
            state_d   = FULL;
          end
          2'b01: state_d = EMPTY;
          default: ;
        endcase
      end
      FULL: begin
        // o_ready is low here, so i_valid cannot be accepted.
        if (acc_out) begin
          load_out_skid = 1'b1;
          state_d       = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Output flags are decoded from the next state and registered, keeping
  // them glitch-free and one flop away from every input. o_ready stays low
  // for the reset cycle itself and rises on the first edge after release.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_ready <= 1'b0;
      o_data  <= '0;
      skid_q  <= '0;
    end else begin
      o_valid <= (state_d != EMPTY);
      o_ready <= (state_d != FULL);
      if (load_out_in)        o_data <= i_data;
      else if (load_out_skid) o_data <= skid_q;
      // SKID only ever captures an accepted word, so it never carries X.
      if (load_skid) skid_q <= i_data;
    end
  end

`ifdef PIPE_SKID_STATS_EN
  // Counts output handshakes; wraps silently.
  always_ff @(posedge i_clk) begin
    if (i_rst)        o_xfer_count <= '0;
    else if (acc_out) o_xfer_count <= o_xfer_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_pipe_skid.sv
// Bench for pipe_skid: directed scenarios plus a randomized stall run checked
// against a queue model of the words in flight.
module tb_pipe_skid;
  localparam int W  = 32;
  localparam int WC = 4;

  logic          i_clk = 1'b0;
  logic          i_rst, i_valid, i_ready;
  logic [W-1:0]  i_data;
  logic          o_ready, o_valid;
  logic [W-1:0]  o_data;
`ifdef PIPE_SKID_STATS_EN
  logic [WC-1:0] o_xfer_count;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  pipe_skid #(.W_DATA(W), .W_CNT(WC)) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_data (i_data),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_data (o_data)
`ifdef PIPE_SKID_STATS_EN
    ,
    .o_xfer_count(o_xfer_count)
`endif
  );

  always #5 i_clk = ~i_clk;

  // Advance one cycle; inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_data = '0;
    tick(); tick();
    n_chk++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0h exp 0", o_valid); end
    n_chk++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %0h exp 0", o_ready); end
    n_chk++; if (o_data !== '0) begin n_fail++; $display("FAIL reset_data got %0h exp 0", o_data); end
`ifdef PIPE_SKID_STATS_EN
    n_chk++; if (o_xfer_count !== '0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", o_xfer_count); end
`endif
    i_rst = 1'b0;
    tick();
    n_chk++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready got %0h exp 1", o_ready); end
    n_chk++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL release_valid got %0h exp 0", o_valid); end
  endtask

  task automatic test_stream();
    i_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      i_valid = 1'b1; i_data = W'(k);
      tick();
      n_chk++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d] got %0h exp 1", k, o_valid); end
      n_chk++; if (o_data !== W'(k)) begin n_fail++; $display("FAIL stream_data[%0d] got %0h exp %0h", k, o_data, k); end
      n_chk++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready[%0d] got %0h exp 1", k, o_ready); end
    end
    i_valid = 1'b0;
    tick();
    n_chk++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drained got %0h exp 0", o_valid); end
  endtask

  task automatic test_backpressure();
    i_ready = 1'b0; i_valid = 1'b1; i_data = 32'hA;
    tick();
    n_chk++; if (o_data !== 32'hA || o_valid !== 1'b1) begin n_fail++; $display("FAIL bp_busy got v=%0h d=%0h exp v=1 d=a", o_valid, o_data); end
    i_data = 32'hB;
    tick();
    n_chk++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready got %0h exp 0", o_ready); end
    n_chk++; if (o_data !== 32'hA) begin n_fail++; $display("FAIL bp_full_data got %0h exp a", o_data); end
    i_data = 32'hC;
    tick();
    n_chk++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL bp_third_ready got %0h exp 0", o_ready); end
    n_chk++; if (o_data !== 32'hA || o_valid !== 1'b1) begin n_fail++; $display("FAIL bp_stable got v=%0h d=%0h exp v=1 d=a", o_valid, o_data); end
    // Drain: 0xA leaves this cycle, 0xC stays offered.
    i_ready = 1'b1;
    tick();
    n_chk++; if (o_data !== 32'hB || o_valid !== 1'b1) begin n_fail++; $display("FAIL drain_b got v=%0h d=%0h exp v=1 d=b", o_valid, o_data); end
    n_chk++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL drain_ready got %0h exp 1", o_ready); end
    tick();
    n_chk++; if (o_data !== 32'hC || o_valid !== 1'b1) begin n_fail++; $display("FAIL drain_c got v=%0h d=%0h exp v=1 d=c", o_valid, o_data); end
    i_valid = 1'b0;
    tick();
    n_chk++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty got %0h exp 0", o_valid); end
  endtask

  task automatic test_reset_full();
    i_ready = 1'b0; i_valid = 1'b1; i_data = 32'hA;
    tick();
    i_data = 32'hB;
    tick();
    n_chk++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL rf_full got %0h exp 0", o_ready); end
    i_valid = 1'b0; i_rst = 1'b1;
    tick();
    n_chk++; if (o_valid !== 1'b0 || o_ready !== 1'b0 || o_data !== '0) begin
      n_fail++; $display("FAIL rf_reset got v=%0h r=%0h d=%0h exp 0 0 0", o_valid, o_ready, o_data);
    end
    i_rst = 1'b0;
    tick();
    i_valid = 1'b1; i_data = 32'h55; i_ready = 1'b1;
    tick();
    n_chk++; if (o_data !== 32'h55 || o_valid !== 1'b1) begin n_fail++; $display("FAIL rf_new got v=%0h d=%0h exp v=1 d=55", o_valid, o_data); end
    i_valid = 1'b0;
    tick();
    n_chk++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rf_no_stale got v=%0h d=%0h exp v=0", o_valid, o_data); end
  endtask

  // Model: the stage is a FIFO of at most two words. Head is shown on o_data,
  // it is non-empty exactly when o_valid, and it accepts while it holds < 2.
  task automatic test_random();
    logic [W-1:0]  mq[$];
    logic [W-1:0]  pd, prev_data;
    logic          pv, er, ev, acc_in, acc_out, hold;
    logic [WC-1:0] ecnt;
    int            outs, nsent, cyc, bad;
    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
    tick();
    i_rst = 1'b0;
    tick();
    er = 1'b1; ev = 1'b0; pv = 1'b0; pd = '0; ecnt = '0;
    outs = 0; nsent = 0; cyc = 0; bad = 0;
    while (outs < 1000 && cyc < 20000) begin
      if (!pv && nsent < 1000) begin
        pv = ($urandom_range(0, 1) == 1);
        if (pv) pd = $urandom;
      end
      i_valid = pv; i_data = pd;
      i_ready = ($urandom_range(0, 1) == 1);
      acc_in  = pv && er;
      acc_out = ev && i_ready;
      hold    = ev && !i_ready;
      prev_data = o_data;
      tick();
      cyc++;
      if (acc_out) begin void'(mq.pop_front()); outs++; ecnt++; end
      if (acc_in)  begin mq.push_back(pd); pv = 1'b0; nsent++; end
      er = (mq.size() < 2);
      ev = (mq.size() > 0);
      n_chk++; if (o_ready !== er) begin n_fail++; bad++; if (bad < 10) $display("FAIL rnd_ready cyc %0d got %0h exp %0h", cyc, o_ready, er); end
      n_chk++; if (o_valid !== ev) begin n_fail++; bad++; if (bad < 10) $display("FAIL rnd_valid cyc %0d got %0h exp %0h", cyc, o_valid, ev); end
      if (ev) begin
        n_chk++; if (o_data !== mq[0]) begin n_fail++; bad++; if (bad < 10) $display("FAIL rnd_data cyc %0d got %0h exp %0h", cyc, o_data, mq[0]); end
      end
      if (hold) begin
        n_chk++; if (o_data !== prev_data) begin n_fail++; bad++; if (bad < 10) $display("FAIL rnd_stable cyc %0d got %0h exp %0h", cyc, o_data, prev_data); end
      end
    end
    n_chk++; if (outs != 1000) begin n_fail++; $display("FAIL rnd_count got %0d words exp 1000 within budget", outs); end
`ifdef PIPE_SKID_STATS_EN
    n_chk++; if (o_xfer_count !== ecnt) begin n_fail++; $display("FAIL rnd_xfer_count got %0d exp %0d", o_xfer_count, ecnt); end
`endif
    i_valid = 1'b0; i_ready = 1'b1;
    tick(); tick();
  endtask

`ifdef PIPE_SKID_STATS_EN
  task automatic test_stats();
    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    tick();
    i_rst = 1'b0;
    tick();
    for (int k = 0; k < 17; k++) begin
      i_valid = 1'b1; i_data = W'(k);
      tick();
    end
    i_valid = 1'b0;
    tick();
    n_chk++; if (o_xfer_count !== 4'd1) begin n_fail++; $display("FAIL stats_wrap got %0d exp 1", o_xfer_count); end
    i_rst = 1'b1;
    tick();
    n_chk++; if (o_xfer_count !== 4'd0) begin n_fail++; $display("FAIL stats_reset got %0d exp 0", o_xfer_count); end
    i_rst = 1'b0;
    tick();
  endtask
`endif

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_data = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_reset_full();
    test_random();
`ifdef PIPE_SKID_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
